// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the iterative mult/div unit.
// The EX side drives operands and HI/LO accesses; the unit returns status and HI/LO.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             intterupt;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             hiloaccess;
    logic             hiwrite;
    logic             lowrite;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             stallEX;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output intterupt, start, op, in1, in2,
        output hiloaccess, hiwrite, lowrite, wdata,
        input  busy, stallEX, done, hi, lo
    );

    modport slave (
        input  intterupt, start, op, in1, in2,
        input  hiloaccess, hiwrite, lowrite, wdata,
        output busy, stallEX, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide unit owning HI/LO.
// Runs on magnitudes for WIDTH steps, then sign-corrects in a single FIX cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_done;

    logic               w_busy;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_dz;

    // op[0]=0 selects the signed variants
    assign w_sa   = ~bus.op[0] & bus.in1[WIDTH-1];
    assign w_sb   = ~bus.op[0] & bus.in2[WIDTH-1];
    assign w_mag1 = w_sa ? -bus.in1 : bus.in1;
    assign w_mag2 = w_sb ? -bus.in2 : bus.in2;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // remainder is always below the divisor, so one extra bit holds the shift
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial    = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_trial[WIDTH]
                      ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_neg  = r_sa ^ r_sb;
    assign w_prod = w_neg ? -r_acc : r_acc;
    assign w_quo  = w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_dz   = (r_b == '0);

    assign w_busy      = (r_state != S_IDLE);
    assign bus.busy    = w_busy;
    assign bus.stallEX = w_busy && (bus.start || bus.hiloaccess);
    assign bus.done    = r_done;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_in1    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.intterupt) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.hiwrite) r_hi <= bus.wdata;
                        if (bus.lowrite) r_lo <= bus.wdata;
                        if (bus.start) begin
                            r_state  <= S_RUN;
                            r_cnt    <= '0;
                            r_is_div <= bus.op[1];
                            r_sa     <= w_sa;
                            r_sb     <= w_sb;
                            r_in1    <= bus.in1;
                            r_b      <= w_mag2;
                            r_acc    <= {{WIDTH{1'b0}}, w_mag1};
                        end
                    end
                    S_RUN: begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                    end
                    S_FIX: begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod;
                        end else if (w_dz) begin
                            r_hi <= r_in1;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Random and directed bench for muldiv_sequencer against a plain-arithmetic model.
// Inputs change and outputs are sampled on the falling edge.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] eh,
                                  output logic [31:0] el);
        longint    sa;
        longint    sb;
        int        ia;
        int        ib;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        eh = '0;
        el = '0;
        case (op)
            2'd0: begin
                p = 64'(sa * sb);
                {eh, el} = p;
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {eh, el} = p;
            end
            2'd2: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'd0;
                    el = 32'h8000_0000;
                end else begin
                    el = 32'(ia / ib);
                    eh = 32'(ia % ib);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    // caller is on a falling edge; returns on the falling edge where done is high
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] xh,
                          input logic [31:0] xl, input string tag);
        int n;
        int nb;
        bus.start = 1'b1;
        bus.op    = o;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in1   = $urandom;
        bus.in2   = $urandom;
        n  = 1;
        nb = 0;
        while (!bus.done && n < 60) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd34);
        chk({tag, "_busy"}, 64'(nb), 64'd33);
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, {xh, xl});
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        bit          seen;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.intterupt  = 1'b0;
        bus.start      = 1'b0;
        bus.op         = 2'd0;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.hiloaccess = 1'b0;
        bus.hiwrite    = 1'b0;
        bus.lowrite    = 1'b0;
        bus.wdata      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_flags", {61'd0, bus.busy, bus.done, bus.stallEX}, 64'd0);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "multu_max");
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd0);
        run_op(2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_zero");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        @(negedge clk);

        // consumer stall, mthi and a second start held while busy
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.in1   = 32'hFFFF_FFF9;
        bus.in2   = 32'd2;
        #1;
        chk("stall_idle", 64'(bus.stallEX), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 60) begin
            if (n == 5) begin
                bus.hiloaccess = 1'b1;
                bus.hiwrite    = 1'b1;
                bus.wdata      = 32'h0000_DEAD;
                #1;
            end
            if (n == 10) begin
                bus.start = 1'b1;
                bus.op    = 2'd1;
                #1;
            end
            if (n == 11) bus.start = 1'b0;
            if (n >= 5) chk("stall_busy", 64'(bus.stallEX), 64'd1);
            @(negedge clk);
            n++;
        end
        chk("stall_lat", 64'(n), 64'd34);
        chk("stall_done", 64'(bus.stallEX), 64'd0);
        chk("stall_hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        @(negedge clk);
        chk("mthi_held", {bus.hi, bus.lo}, {32'h0000_DEAD, 32'hFFFF_FFFD});
        chk("no_restart", 64'(bus.busy), 64'd0);
        bus.hiloaccess = 1'b0;
        bus.hiwrite    = 1'b0;

        bus.hiwrite = 1'b1;
        bus.wdata   = 32'h1234;
        @(negedge clk);
        bus.hiwrite = 1'b0;
        chk("mthi_idle", {bus.hi, bus.lo}, {32'h1234, 32'hFFFF_FFFD});
        bus.hiwrite = 1'b1;
        bus.lowrite = 1'b1;
        bus.wdata   = 32'h55;
        @(negedge clk);
        chk("mthilo", {bus.hi, bus.lo}, {32'h55, 32'h55});

        // abort: preload HI/LO, flush mid-divide
        bus.lowrite = 1'b0;
        bus.wdata   = 32'hAA;
        @(negedge clk);
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b1;
        bus.wdata   = 32'hBB;
        @(negedge clk);
        bus.lowrite = 1'b0;
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.in1   = 32'd50;
        bus.in2   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.intterupt = 1'b1;
        @(negedge clk);
        bus.intterupt = 1'b0;
        chk("int_busy", 64'(bus.busy), 64'd0);
        chk("int_hilo", {bus.hi, bus.lo}, {32'hAA, 32'hBB});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("int_nodone", 64'(seen), 64'd0);
        bus.start     = 1'b1;
        bus.intterupt = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.intterupt = 1'b0;
        chk("int_start", 64'(bus.busy), 64'd0);
        run_op(2'd3, 32'd50, 32'd7, 32'd1, 32'd7, "divu_after");
        @(negedge clk);

        // reset in the middle of a multiply
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.in1   = 32'd9;
        bus.in2   = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // back-to-back and random operations
        model(2'd1, 32'd6, 32'd7, eh, el);
        run_op(2'd1, 32'd6, 32'd7, eh, el, "b2b_a");
        run_op(2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, "b2b_b");
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = rnd_val();
            b = rnd_val();
            model(o, a, b, eh, el);
            run_op(o, a, b, eh, el, $sformatf("rnd%0d_op%0d", i, o));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
